up_down_counter_nbit: RTL and testbench
=======================================

// Module: up_down_counter_nbit
// PURPOSE
//   Parametrised synchronous up/down modulo counter; next generation of the 3-bit up counter.
//   Adds generic width, programmable modulus, count enable, direction control, parallel load,
//   a terminal-count flag and a wrap pulse. Used as the shared timebase/sequencer counter
//   in counter-based datapaths.
// PARAMETERS
//   WIDTH      8    counter width in bits (>=1)
//   MODULUS    256  count range 0..MODULUS-1; legal range 2..2**WIDTH
//   RESET_VAL  0    value of Q after reset; must be < MODULUS
// PORTS
//   clk       in   1      rising-edge clock, sole clock
//   reset     in   1      synchronous, active-high reset
//   en        in   1      count enable; counter holds when low
//   up_dn     in   1      1 = count up, 0 = count down
//   load      in   1      synchronous parallel load strobe
//   load_val  in   WIDTH  value to load
//   Q         out  WIDTH  registered count
//   tc        out  1      terminal count, combinational: en & ((up_dn & Q==MODULUS-1) | (~up_dn & Q==0))
//   wrap      out  1      registered one-cycle pulse: previous edge wrapped the count
// BEHAVIOUR
//   - All state updates on posedge clk. One clock; reset is synchronous and active-high.
//   - Priority per edge: reset > load > en > hold.
//   - reset: Q <= RESET_VAL, wrap <= 0. tc follows Q/en combinationally.
//   - load: Q <= load_val. If load_val >= MODULUS, Q <= MODULUS-1 (clamp). wrap <= 0.
//     Load overrides counting regardless of en/up_dn.
//   - en & up_dn: Q <= (Q==MODULUS-1) ? 0 : Q+1.
//   - en & ~up_dn: Q <= (Q==0) ? MODULUS-1 : Q-1.
//   - ~en & ~load: Q holds, wrap <= 0.
//   - wrap <= 1 exactly on edges where a counting step took the wrap branch; else 0.
//   - Latency: Q changes one edge after en/load sampled; wrap aligned with wrapped Q.
//   - Arithmetic is modulo MODULUS, never 2**WIDTH unless MODULUS==2**WIDTH.
//     Internal +1/-1 must not overflow WIDTH bits.
//   - Direction change mid-count takes effect on the next enabled edge, no extra cycle.
//   - Reset asserted mid-count: Q = RESET_VAL on that edge; no wrap pulse.
//   - No X on outputs after first reset edge; outputs undefined before first reset.
// CONFIGURATION
//   Macro UP_DOWN_COUNTER_SAT_EN:
//   - Defined: saturating mode. Up at MODULUS-1 holds MODULUS-1; down at 0 holds 0.
//     wrap is tied 0. tc is unchanged, and signals saturation when en is high.
//   - Undefined (default): modulo wrap-around as described above.
// TESTING  (WIDTH=4, MODULUS=10, RESET_VAL=0 unless stated)
//   1. reset 1 cycle, en=1, up_dn=1, 12 edges ->
//      Q 1..9,0,1,2; tc=1 while Q=9; wrap=1 only in the cycle Q=0.
//   2. Q=0, en=1, up_dn=0, 1 edge -> Q=9, wrap=1.
//      Next edge -> Q=8, wrap=0.
//   3. load=1, load_val=7, en=1 same edge -> Q=7 (load wins).
//      load_val=13 -> Q=9 (clamp).
//   4. Counting at Q=5, assert reset with en=1, load=1 -> Q=0, wrap=0 on that edge.
//   5. en=0 for 5 edges at Q=4 -> Q stays 4, tc=0, wrap=0.
//      Toggle up_dn each edge with en=1 -> Q 5,4,5,4.
//   6. UP_DOWN_COUNTER_SAT_EN defined: count up from 8 for 4 edges -> Q 9,9,9,9, wrap=0, tc=1.
//      Down from 1 for 3 edges -> Q 0,0,0.

Source files
------------

// File: rtl/up_down_counter_nbit.sv
// Parametrised synchronous up/down modulo counter with load, terminal count and wrap pulse.
// Define UP_DOWN_COUNTER_SAT_EN for saturating mode (holds at the ends, wrap tied 0).
module up_down_counter_nbit #(
  parameter int WIDTH     = 8,
  parameter int MODULUS   = 256,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] QMAX  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] QRST  = WIDTH'(RESET_VAL);
  // One extra bit so MODULUS == 2**WIDTH is representable and no load value clamps.
  localparam logic [WIDTH:0]   LIMIT = (WIDTH + 1)'(MODULUS);

  logic             at_max;
  logic             at_min;
  logic [WIDTH-1:0] q_nxt;
  logic             wrap_nxt;

  assign at_max = (Q == QMAX);
  assign at_min = (Q == '0);
  assign tc     = en & ((up_dn & at_max) | (~up_dn & at_min));

  always_comb begin
    q_nxt    = Q;
    wrap_nxt = 1'b0;
    if (load) begin
      q_nxt = ({1'b0, load_val} >= LIMIT) ? QMAX : load_val;
    end else if (en) begin
      if (up_dn) begin
        if (at_max) begin
`ifdef UP_DOWN_COUNTER_SAT_EN
          q_nxt    = QMAX;
`else
          q_nxt    = '0;
          wrap_nxt = 1'b1;
`endif
        end else begin
          q_nxt = Q + WIDTH'(1);
        end
      end else begin
        if (at_min) begin
`ifdef UP_DOWN_COUNTER_SAT_EN
          q_nxt    = '0;
`else
          q_nxt    = QMAX;
          wrap_nxt = 1'b1;
`endif
        end else begin
          q_nxt = Q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      Q    <= QRST;
      wrap <= 1'b0;
    end else begin
      Q    <= q_nxt;
      wrap <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_up_down_counter_nbit.sv
// Bench for up_down_counter_nbit (WIDTH=4, MODULUS=10): directed vector table plus random vs model.
module tb_up_down_counter_nbit;

  localparam int W   = 4;
  localparam int MOD = 10;

  logic         clk = 1'b0;
  logic         reset, en, up_dn, load;
  logic [W-1:0] load_val;
  logic [W-1:0] q;
  logic         tc, wrap;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic         rst;
    logic         en;
    logic         up;
    logic         ld;
    logic [W-1:0] lv;
    logic [W-1:0] q;
    logic         tc;
    logic         wr;
  } vec_t;

  vec_t vq[$];

  up_down_counter_nbit #(.WIDTH(W), .MODULUS(MOD), .RESET_VAL(0)) dut (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .Q(q), .tc(tc), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic e, input logic u, input logic l, input int lv,
                     input int eq, input logic etc, input logic ew);
    vec_t v;
    v.rst = r; v.en = e; v.up = u; v.ld = l; v.lv = W'(lv);
    v.q = W'(eq); v.tc = etc; v.wr = ew;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step(input logic r, input logic e, input logic u, input logic l, input logic [W-1:0] lv);
    @(negedge clk);
    reset = r; en = e; up_dn = u; load = l; load_val = lv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int mq, nq, ew, etc;
    logic r, e, u, l;
    logic [W-1:0] lv;

    reset = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;

    // reset state, then directed scenarios
    add(1, 1, 1, 0, 0,  0, 0, 0);
`ifndef UP_DOWN_COUNTER_SAT_EN
    for (int i = 1; i <= 12; i++)
      add(0, 1, 1, 0, 0, i % MOD, (i % MOD) == 9, (i % MOD) == 0);
    add(0, 1, 1, 1, 7,  7, 0, 0);   // load beats en
    add(0, 1, 1, 1, 13, 9, 1, 0);   // clamp
    add(1, 0, 0, 0, 0,  0, 0, 0);
    add(0, 1, 0, 0, 0,  9, 0, 1);   // down wrap
    add(0, 1, 0, 0, 0,  8, 0, 0);
    add(0, 0, 1, 1, 4,  4, 0, 0);
    add(0, 1, 1, 0, 0,  5, 0, 0);
    add(1, 1, 1, 1, 3,  0, 0, 0);   // reset beats load/en mid-count
    add(0, 0, 1, 1, 9,  9, 0, 0);   // tc gated by en
    add(1, 1, 1, 0, 0,  0, 0, 0);   // reset suppresses would-be wrap
    add(0, 0, 1, 1, 4,  4, 0, 0);
    for (int i = 0; i < 5; i++)
      add(0, 0, i[0], 0, 0, 4, 0, 0);
    add(0, 1, 1, 0, 0,  5, 0, 0);
    add(0, 1, 0, 0, 0,  4, 0, 0);
    add(0, 1, 1, 0, 0,  5, 0, 0);
    add(0, 1, 0, 0, 0,  4, 0, 0);
    add(0, 0, 0, 1, 1,  1, 0, 0);
    add(0, 1, 0, 0, 0,  0, 1, 0);   // tc on down at zero
    add(0, 1, 0, 0, 0,  9, 0, 1);
`else
    add(0, 0, 1, 1, 8,  8, 0, 0);
    for (int i = 0; i < 4; i++)
      add(0, 1, 1, 0, 0, 9, 1, 0);
    add(0, 0, 0, 1, 1,  1, 0, 0);
    for (int i = 0; i < 3; i++)
      add(0, 1, 0, 0, 0, 0, 1, 0);
    add(0, 1, 1, 1, 13, 9, 1, 0);
`endif

    foreach (vq[k]) begin
      step(vq[k].rst, vq[k].en, vq[k].up, vq[k].ld, vq[k].lv);
      chk($sformatf("vec%0d_q", k),    int'(q),    int'(vq[k].q));
      chk($sformatf("vec%0d_tc", k),   int'(tc),   int'(vq[k].tc));
      chk($sformatf("vec%0d_wrap", k), int'(wrap), int'(vq[k].wr));
    end

    // random traffic against an arithmetic model
    mq = 0;
    for (int i = 0; i < 400; i++) begin
      r  = (i == 0) || ($urandom_range(0, 31) == 0);
      l  = ($urandom_range(0, 7) == 0);
      e  = ($urandom_range(0, 3) != 0);
      u  = 1'($urandom_range(0, 1));
      lv = W'($urandom_range(0, 15));
      ew = 0;
      if (r) nq = 0;
      else if (l) nq = (int'(lv) >= MOD) ? MOD - 1 : int'(lv);
      else if (e) begin
`ifndef UP_DOWN_COUNTER_SAT_EN
        nq = (mq + (u ? 1 : MOD - 1)) % MOD;
        ew = u ? (nq == 0) : (nq == MOD - 1);
`else
        nq = u ? ((mq + 1 > MOD - 1) ? MOD - 1 : mq + 1) : ((mq - 1 < 0) ? 0 : mq - 1);
`endif
      end else nq = mq;
      mq  = nq;
      etc = e && ((u && mq == MOD - 1) || (!u && mq == 0));
      step(r, e, u, l, lv);
      chk($sformatf("rnd%0d_q", i),    int'(q),    mq);
      chk($sformatf("rnd%0d_tc", i),   int'(tc),   etc);
      chk($sformatf("rnd%0d_wrap", i), int'(wrap), ew);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
